// File: rtl/gb_bus_pkg.sv
// rtl/gb_bus_pkg.sv - shared register offsets, timer state encoding and TAC tick-bit table
package gb_bus_pkg;

    localparam logic [1:0] REG_DIV  = 2'd0;
    localparam logic [1:0] REG_TIMA = 2'd1;
    localparam logic [1:0] REG_TMA  = 2'd2;
    localparam logic [1:0] REG_TAC  = 2'd3;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_OVF = 1'b1
    } tima_state_e;

    // div_cnt bit that drives the TIMA tick for each TAC clock select
    function automatic logic [3:0] tac_bit_sel(input logic [1:0] clk_sel);
        logic [3:0] idx;
        case (clk_sel)
            2'b00:   idx = 4'd9;
            2'b01:   idx = 4'd3;
            2'b10:   idx = 4'd5;
            default: idx = 4'd7;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/timer.sv
// rtl/timer.sv - DIV/TIMA/TMA/TAC timer with delayed overflow reload and 1-clock irq pulse
module timer
    import gb_bus_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hFF04
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    input  logic        rd,
    input  logic        wr,
    output logic        hit,
    output logic        irq
);

    logic [15:0] div_cnt_q, div_cnt_d;
    logic [7:0]  tima_q, tima_d;
    logic [7:0]  tma_q, tma_d;
    logic [2:0]  tac_q, tac_d;
    logic        tick_prev_q, tick_prev_d;
    tima_state_e state_q, state_d;
    logic [1:0]  dly_q, dly_d;
    logic        irq_q, irq_d;
    logic [7:0]  dout_q, dout_d;

    logic [15:0] off;
    logic [1:0]  reg_sel;
    logic        wr_en, rd_en;
    logic        wr_tima, wr_tma;
    logic        tick_sig, tick_fall;
    logic [7:0]  read_val;

    assign off     = a - BASE_ADDR;
    assign hit     = (off < 16'd4);
    assign reg_sel = off[1:0];
    assign wr_en   = wr & hit;
    assign rd_en   = rd & hit;
    assign wr_tima = wr_en && (reg_sel == REG_TIMA);
    assign wr_tma  = wr_en && (reg_sel == REG_TMA);

    // Falling edge of the gated tick; DIV/TAC writes that drop it also count
    assign tick_sig  = tac_q[2] & div_cnt_q[tac_bit_sel(tac_q[1:0])];
    assign tick_fall = tick_prev_q & ~tick_sig;

    always_comb begin
        read_val = 8'hFF;
        case (reg_sel)
            REG_DIV:  read_val = div_cnt_q[15:8];
            REG_TIMA: read_val = tima_q;
            REG_TMA:  read_val = tma_q;
            default:  read_val = {5'b11111, tac_q};
        endcase
    end

    always_comb begin
        div_cnt_d   = div_cnt_q + 16'd1;
        tma_d       = tma_q;
        tac_d       = tac_q;
        tick_prev_d = tick_sig;
        tima_d      = tima_q;
        state_d     = state_q;
        dly_d       = dly_q;
        irq_d       = 1'b0;
        dout_d      = rd_en ? read_val : 8'hFF;

        if (wr_en && (reg_sel == REG_DIV)) div_cnt_d = 16'd0;
        if (wr_tma) tma_d = din;
        if (wr_en && (reg_sel == REG_TAC)) tac_d = din[2:0];

        case (state_q)
            ST_RUN: begin
                if (wr_tima) begin
                    tima_d = din;
                end else if (tick_fall) begin
                    if (tima_q == 8'hFF) begin
                        tima_d  = 8'h00;
                        state_d = ST_OVF;
                        dly_d   = 2'd3;
                    end else begin
                        tima_d = tima_q + 8'd1;
                    end
                end
            end
            default: begin
                // Ticks are dropped while the reload is pending
                if (wr_tima) begin
                    tima_d  = din;
                    state_d = ST_RUN;
                    dly_d   = 2'd0;
                end else if (dly_q == 2'd0) begin
                    tima_d  = wr_tma ? din : tma_q;
                    irq_d   = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    dly_d = dly_q - 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q   <= 16'd0;
            tima_q      <= 8'd0;
            tma_q       <= 8'd0;
            tac_q       <= 3'd0;
            tick_prev_q <= 1'b0;
            state_q     <= ST_RUN;
            dly_q       <= 2'd0;
            irq_q       <= 1'b0;
            dout_q      <= 8'hFF;
        end else begin
            div_cnt_q   <= div_cnt_d;
            tima_q      <= tima_d;
            tma_q       <= tma_d;
            tac_q       <= tac_d;
            tick_prev_q <= tick_prev_d;
            state_q     <= state_d;
            dly_q       <= dly_d;
            irq_q       <= irq_d;
            dout_q      <= dout_d;
        end
    end

    assign dout = dout_q;
    assign irq  = irq_q;

endmodule

// File: doc/timer.md
TIMER -- requirements
Module: timer

Interface
REQ-001 Parameter BASE_ADDR, default 16'hFF04, is the address of the first timer register (DIV); TIMA, TMA and TAC are at BASE_ADDR+1, +2 and +3.
REQ-002 Port clk, input, 1: system clock, 4 clocks per CPU M-cycle.
REQ-003 Port rst, input, 1: reset; one clock; reset is asynchronous and active-high.
REQ-004 Port a, input, 16: CPU address bus.
REQ-005 Port din, input, 8: CPU write data, valid while wr=1.
REQ-006 Port dout, output, 8: read data to CPU, registered.
REQ-007 Port rd, input, 1: CPU read strobe, high for 2 clocks per read M-cycle.
REQ-008 Port wr, input, 1: CPU write strobe, high for 1 clock per write M-cycle.
REQ-009 Port hit, output, 1: combinational; 1 when a is within BASE_ADDR..BASE_ADDR+3, for the system read mux.
REQ-010 Port irq, output, 1: timer interrupt request, a 1-clock pulse.

Function
REQ-011 div_cnt: 16-bit, increments every clk and wraps 16'hFFFF->0; DIV reads div_cnt[15:8].
REQ-012 Tick source: TAC[1:0]=00 selects div_cnt[9], 01 selects [3], 10 selects [5], 11 selects [7].
REQ-013 tick_sig = TAC[2] & selected bit; a registered copy detects edges; TIMA increments on the clock after each 1->0 transition of tick_sig, including transitions caused by a DIV write or a TAC write (hardware glitch is reproduced).
REQ-014 Write to DIV (any data): div_cnt <= 0.
REQ-015 Writes: on a clock with wr=1 and hit=1, the addressed register takes din (TAC keeps din[2:0] only).
REQ-016 Reads: on a clock with rd=1 and hit=1, dout <= register value; on all other clocks dout <= 8'hFF. Data is therefore valid by the second rd clock.
REQ-017 Read map: DIV, TIMA, TMA, {5'b11111, TAC}.
REQ-018 Overflow FSM states: RUN, OVF. In RUN, an increment from 8'hFF sets TIMA to 8'h00, enters OVF and loads a 2-bit delay counter with 3.
REQ-019 OVF lasts exactly 4 clocks, during which TIMA reads 8'h00; on the 4th clock TIMA <= TMA, irq=1 for that clock, and the FSM returns to RUN.
REQ-020 A CPU write to TIMA during OVF cancels both the reload and irq; TIMA takes din and the FSM returns to RUN.
REQ-021 A write to TMA on the reload clock: TIMA is loaded with the new din value.
REQ-022 A tick and a TIMA write on the same clock: the write wins and the increment is discarded.
REQ-023 A tick during OVF is discarded.

Reset
REQ-024 On rst: div_cnt=0, TIMA=0, TMA=0, TAC=0, edge register=0, FSM=RUN, delay counter=0, irq=0, dout=8'hFF.
REQ-025 A reset asserted mid-OVF aborts the reload with no irq pulse.

Structure
REQ-026 The register offsets (DIV=0, TIMA=1, TMA=2, TAC=3) and the TAC bit-select table belong in the shared gb_bus_pkg package.
REQ-027 No sub-module: the block is a single flat module.

Verification
REQ-028 Scenario: TAC=3'b101, TIMA=8'hFE, TMA=8'h40, run 48 clocks -> TIMA=FF then 00, 00 is held for 4 clocks, then TIMA=40 with a single irq pulse.
REQ-029 Scenario: write DIV while div_cnt=16'h0230 with TAC=3'b100 (bit 9 = 1) -> div_cnt=0, TIMA increments once, DIV reads 00.
REQ-030 Scenario: overflow, then write TIMA=8'h12 on OVF clock 2 -> TIMA=12, no irq, no later reload.
REQ-031 Scenario: overflow, then write TMA=8'h77 on the reload clock -> TIMA=77, irq=1.
REQ-032 Scenario: read 4 addresses BASE..BASE+3 and BASE+4 after reset -> 00,00,00,F8 with hit=1; for BASE+4, hit=0 and dout=FF.
REQ-033 Scenario: assert rst asynchronously mid-OVF -> all reset values and no irq.
